// File: rtl/video_sprite_render_if.sv
// Pixel stream, config bus and sprite RAM read port of the sprite compositor.
// The compositor (slave) consumes src/cfg/ram_dout and produces ram_addr_r/dst.
interface video_sprite_render_if #(
  parameter int AW = 10,
  parameter int DW = 12,
  parameter int HW = 11
);
  logic          src_vld;
  logic          src_sof;
  logic [HW-1:0] src_x;
  logic [HW-1:0] src_y;
  logic [DW-1:0] src_rgb;

  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [HW-1:0] cfg_wdata;

  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_dout;

  logic          dst_vld;
  logic          dst_sof;
  logic [DW-1:0] dst_rgb;

  modport master (
    output src_vld, src_sof, src_x, src_y, src_rgb,
    output cfg_we, cfg_addr, cfg_wdata,
    output ram_dout,
    input  ram_addr_r,
    input  dst_vld, dst_sof, dst_rgb
  );

  modport slave (
    input  src_vld, src_sof, src_x, src_y, src_rgb,
    input  cfg_we, cfg_addr, cfg_wdata,
    input  ram_dout,
    output ram_addr_r,
    output dst_vld, dst_sof, dst_rgb
  );
endinterface

// File: rtl/video_sprite_render.sv
// Two-stage single-sprite compositor: overlays a chroma-keyed sprite read from an
// external synchronous RAM onto a background pixel stream at a per-frame position.
module video_sprite_render #(
  parameter int              AW        = 10,
  parameter int              DW        = 12,
  parameter int              HW        = 11,
  parameter int              SW_LOG2   = 5,
  parameter int              SH_LOG2   = 5,
  parameter logic [DW-1:0]   KEY_COLOR = 12'h000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  video_sprite_render_if.slave bus
);

  typedef enum logic [1:0] {
    REG_XPOS = 2'd0,
    REG_YPOS = 2'd1,
    REG_EN   = 2'd2,
    REG_RSVD = 2'd3
  } cfg_reg_e;

  localparam logic [HW:0] SPR_W = (HW+1)'(1) << SW_LOG2;
  localparam logic [HW:0] SPR_H = (HW+1)'(1) << SH_LOG2;

  logic [HW-1:0]      xpos_sh, ypos_sh, xpos_act, ypos_act;
  logic               en_sh, en_act;

  logic               sof_load;
  logic [HW-1:0]      xpos_cur, ypos_cur;
  logic               en_cur;
  logic [HW:0]        x_ext, y_ext, xp_ext, yp_ext;
  logic               hit;
  logic [SW_LOG2-1:0] dx;
  logic [SH_LOG2-1:0] dy;
  logic [AW-1:0]      ram_addr;

  logic               vld1, sof1, hit1;
  logic [DW-1:0]      rgb1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos_sh <= '0;
      ypos_sh <= '0;
      en_sh   <= 1'b0;
    end else if (bus.cfg_we) begin
      case (cfg_reg_e'(bus.cfg_addr))
        REG_XPOS: xpos_sh <= bus.cfg_wdata;
        REG_YPOS: ypos_sh <= bus.cfg_wdata;
        REG_EN:   en_sh   <= bus.cfg_wdata[0];
        default:  ;
      endcase
    end
  end

  // Loads the pre-write shadow, so a write coincident with sof lands one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos_act <= '0;
      ypos_act <= '0;
      en_act   <= 1'b0;
    end else if (sof_load) begin
      xpos_act <= xpos_sh;
      ypos_act <= ypos_sh;
      en_act   <= en_sh;
    end
  end

  // The sof pixel already belongs to the new frame, so it bypasses the active registers.
  always_comb begin
    sof_load = bus.src_vld & bus.src_sof;
    xpos_cur = sof_load ? xpos_sh : xpos_act;
    ypos_cur = sof_load ? ypos_sh : ypos_act;
    en_cur   = sof_load ? en_sh   : en_act;
  end

  // One extra bit keeps a window that crosses the right/bottom edge from wrapping to 0.
  always_comb begin
    x_ext  = {1'b0, bus.src_x};
    y_ext  = {1'b0, bus.src_y};
    xp_ext = {1'b0, xpos_cur};
    yp_ext = {1'b0, ypos_cur};
    hit    = en_cur
           && (x_ext >= xp_ext) && (x_ext < (xp_ext + SPR_W))
           && (y_ext >= yp_ext) && (y_ext < (yp_ext + SPR_H));
  end

  always_comb begin
    dx       = bus.src_x[SW_LOG2-1:0] - xpos_cur[SW_LOG2-1:0];
    dy       = bus.src_y[SH_LOG2-1:0] - ypos_cur[SH_LOG2-1:0];
    ram_addr = {dy, dx};
  end

  assign bus.ram_addr_r = ram_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1 <= 1'b0;
      sof1 <= 1'b0;
      hit1 <= 1'b0;
      rgb1 <= '0;
    end else begin
      vld1 <= bus.src_vld;
      sof1 <= bus.src_vld & bus.src_sof;
      hit1 <= hit;
      rgb1 <= bus.src_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dst_vld <= 1'b0;
      bus.dst_sof <= 1'b0;
      bus.dst_rgb <= '0;
    end else begin
      bus.dst_vld <= vld1;
      bus.dst_sof <= sof1;
      bus.dst_rgb <= (hit1 && (bus.ram_dout != KEY_COLOR)) ? bus.ram_dout : rgb1;
    end
  end

endmodule

// File: tb/tb_video_sprite_render.sv
// Bench for video_sprite_render: drives pixel frames and config writes and compares
// the composited output against a coordinate-level reference model of the sprite.
module tb_video_sprite_render;

  typedef struct packed {
    logic        vld;
    logic        sof;
    logic [11:0] rgb;
  } pix_t;

  localparam int KEY = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_sprite_render_if #(.AW(10), .DW(12), .HW(11)) bus ();

  video_sprite_render #(
    .AW(10), .DW(12), .HW(11), .SW_LOG2(5), .SH_LOG2(5), .KEY_COLOR(12'h000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [11:0] ram [1024];
  logic [11:0] ram_q;
  always @(posedge clk) ram_q <= ram[bus.ram_addr_r];
  assign bus.ram_dout = ram_q;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: shadow (s) and per-frame active (a) sprite position/enable.
  int m_xs, m_ys, m_xa, m_ya;
  bit m_es, m_ea;
  pix_t exp_q[$];

  task automatic model_reset();
    m_xs = 0; m_ys = 0; m_xa = 0; m_ya = 0; m_es = 0; m_ea = 0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 12'($urandom_range(1, 4095));
    end
  endtask

  // One clock of stimulus; returns the combinational RAM address seen for this pixel
  // and the output pair (observed, expected) for the pixel driven one step earlier.
  task automatic step(input bit vld, input bit sof, input int x, input int y,
                      input int rgb, input bit we, input int a, input int wd,
                      output logic [9:0] addr, output bit hit, output int exp_addr,
                      output pix_t obs, output pix_t exp, output bit have);
    int X, Y;
    bit E;
    pix_t e;
    bus.src_vld   = vld;
    bus.src_sof   = sof;
    bus.src_x     = 11'(x);
    bus.src_y     = 11'(y);
    bus.src_rgb   = 12'(rgb);
    bus.cfg_we    = we;
    bus.cfg_addr  = 2'(a);
    bus.cfg_wdata = 11'(wd);
    X = (vld && sof) ? m_xs : m_xa;
    Y = (vld && sof) ? m_ys : m_ya;
    E = (vld && sof) ? m_es : m_ea;
    hit = E && (x >= X) && (x < X + 32) && (y >= Y) && (y < Y + 32);
    exp_addr = hit ? (y - Y) * 32 + (x - X) : 0;
    e.vld = vld;
    e.sof = vld && sof;
    e.rgb = 12'(rgb);
    if (hit && (int'(ram[exp_addr]) != KEY)) e.rgb = ram[exp_addr];
    exp_q.push_back(e);
    #1 addr = bus.ram_addr_r;
    @(posedge clk);
    if (vld && sof) begin
      m_xa = m_xs; m_ya = m_ys; m_ea = m_es;
    end
    if (we) begin
      case (a)
        0: m_xs = wd & 2047;
        1: m_ys = wd & 2047;
        2: m_es = wd[0];
        default: ;
      endcase
    end
    @(negedge clk);
    obs.vld = bus.dst_vld;
    obs.sof = bus.dst_sof;
    obs.rgb = bus.dst_rgb;
    have = 1'b0;
    exp = '0;
    if (exp_q.size() >= 2) begin
      exp = exp_q.pop_front();
      have = 1'b1;
    end
  endtask

  task automatic do_reset();
    bus.src_vld = 0; bus.src_sof = 0; bus.src_x = '0; bus.src_y = '0; bus.src_rgb = '0;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_chk++;
    if (bus.dst_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_dst_vld: got %b, required 0", bus.dst_vld);
    end
    n_chk++;
    if (bus.dst_sof !== 1'b0) begin
      n_fail++; $display("FAIL reset_dst_sof: got %b, required 0", bus.dst_sof);
    end
    n_chk++;
    if (bus.dst_rgb !== 12'h000) begin
      n_fail++; $display("FAIL reset_dst_rgb: got %h, required 000", bus.dst_rgb);
    end
    do_reset();
  endtask

  task automatic test_basic();
    // {vld, sof, x, y, we, cfg_addr, cfg_wdata}
    int tbl [16][7] = '{
      '{0,0,0,0,1,0,100}, '{0,0,0,0,1,1,50}, '{0,0,0,0,1,2,1}, '{0,0,0,0,1,3,7},
      '{1,1,100,50,0,0,0}, '{1,0,131,81,0,0,0}, '{1,0,132,50,0,0,0}, '{1,0,104,50,0,0,0},
      '{1,0,99,50,0,0,0},  '{1,0,100,49,0,0,0}, '{1,0,131,50,0,0,0}, '{1,0,100,81,0,0,0},
      '{1,0,100,82,0,0,0}, '{1,0,110,60,0,0,0}, '{0,0,0,0,0,0,0},    '{0,0,0,0,0,0,0}
    };
    logic [9:0] addr; bit hit, have; int ea; pix_t o, e;
    fill_ram();
    ram[4] = 12'h000;
    for (int i = 0; i < 16; i++) begin
      step(tbl[i][0][0], tbl[i][1][0], tbl[i][2], tbl[i][3], $urandom_range(0, 4095),
           tbl[i][4][0], tbl[i][5], tbl[i][6], addr, hit, ea, o, e, have);
      if (hit) begin
        n_chk++;
        if (addr !== 10'(ea)) begin
          n_fail++; $display("FAIL basic_addr[%0d]: got %0d, required %0d", i, addr, ea);
        end
      end
      if (have) begin
        n_chk++;
        if (o.vld !== e.vld || o.sof !== e.sof || (e.vld && o.rgb !== e.rgb)) begin
          n_fail++;
          $display("FAIL basic_pix[%0d]: got vld/sof/rgb %b/%b/%h, required %b/%b/%h",
                   i, o.vld, o.sof, o.rgb, e.vld, e.sof, e.rgb);
        end
      end
    end
  endtask

  task automatic test_frame_update();
    int tbl [14][7] = '{
      '{0,0,0,0,1,0,100},  '{0,0,0,0,1,1,50},   '{0,0,0,0,1,2,1},
      '{1,1,100,50,0,0,0}, '{1,0,105,52,1,0,200}, '{1,0,100,55,0,0,0}, '{1,0,200,55,0,0,0},
      '{1,1,200,50,1,0,300}, '{1,0,300,51,0,0,0}, '{1,0,200,51,0,0,0}, '{1,0,231,81,0,0,0},
      '{1,1,300,50,0,0,0}, '{1,0,200,52,0,0,0},  '{0,0,0,0,0,0,0}
    };
    logic [9:0] addr; bit hit, have; int ea; pix_t o, e;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i][0][0], tbl[i][1][0], tbl[i][2], tbl[i][3], $urandom_range(0, 4095),
           tbl[i][4][0], tbl[i][5], tbl[i][6], addr, hit, ea, o, e, have);
      if (have) begin
        n_chk++;
        if (o.vld !== e.vld || o.sof !== e.sof || (e.vld && o.rgb !== e.rgb)) begin
          n_fail++;
          $display("FAIL frame_update_pix[%0d]: got vld/sof/rgb %b/%b/%h, required %b/%b/%h",
                   i, o.vld, o.sof, o.rgb, e.vld, e.sof, e.rgb);
        end
      end
    end
  endtask

  task automatic test_edge();
    logic [9:0] addr; bit hit, have; int ea; pix_t o, e;
    int xs [40];
    int ys [40];
    xs[0] = 2047; ys[0] = 0;
    xs[1] = 2047; ys[1] = 31;
    xs[2] = 2046; ys[2] = 0;
    xs[3] = 2047; ys[3] = 32;
    for (int i = 4; i < 35; i++) begin xs[i] = i - 4; ys[i] = 0; end
    for (int i = 35; i < 40; i++) begin xs[i] = 2047; ys[i] = i - 30; end
    step(0, 0, 0, 0, 0, 1, 0, 2047, addr, hit, ea, o, e, have);
    step(0, 0, 0, 0, 0, 1, 1, 0, addr, hit, ea, o, e, have);
    step(0, 0, 0, 0, 0, 1, 2, 1, addr, hit, ea, o, e, have);
    for (int i = 0; i < 42; i++) begin
      if (i < 40)
        step(1, i == 0, xs[i], ys[i], $urandom_range(0, 4095), 0, 0, 0, addr, hit, ea, o, e, have);
      else
        step(0, 0, 0, 0, 0, 0, 0, 0, addr, hit, ea, o, e, have);
      if (hit) begin
        n_chk++;
        if (addr !== 10'(ea)) begin
          n_fail++; $display("FAIL edge_addr[%0d]: got %0d, required %0d", i, addr, ea);
        end
      end
      if (have) begin
        n_chk++;
        if (o.vld !== e.vld || o.sof !== e.sof || (e.vld && o.rgb !== e.rgb)) begin
          n_fail++;
          $display("FAIL edge_pix[%0d]: got vld/sof/rgb %b/%b/%h, required %b/%b/%h",
                   i, o.vld, o.sof, o.rgb, e.vld, e.sof, e.rgb);
        end
      end
    end
  endtask

  task automatic test_vld_gaps();
    bit pat [8] = '{1, 0, 1, 1, 0, 0, 0, 0};
    logic [9:0] addr; bit hit, have; int ea; pix_t o, e;
    step(0, 0, 0, 0, 0, 1, 0, 10, addr, hit, ea, o, e, have);
    step(0, 0, 0, 0, 0, 1, 1, 10, addr, hit, ea, o, e, have);
    for (int i = 0; i < 8; i++) begin
      step(pat[i], i == 0, 10 + i, 12, $urandom_range(0, 4095), 0, 0, 0, addr, hit, ea, o, e, have);
      if (have) begin
        n_chk++;
        if (o.vld !== e.vld || o.sof !== e.sof || (e.vld && o.rgb !== e.rgb)) begin
          n_fail++;
          $display("FAIL vld_gap_pix[%0d]: got vld/sof/rgb %b/%b/%h, required %b/%b/%h",
                   i, o.vld, o.sof, o.rgb, e.vld, e.sof, e.rgb);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    logic [9:0] addr; bit hit, have; int ea; pix_t o, e;
    int X, Y, x, y, a;
    bit vld, sof, we;
    fill_ram();
    for (int k = 0; k < 40; k++) ram[$urandom_range(0, 1023)] = 12'h000;
    for (int f = 0; f < 6; f++) begin
      X = (f == 4) ? 2030 : $urandom_range(0, 2047);
      Y = (f == 5) ? 2040 : $urandom_range(0, 2047);
      step(0, 0, 0, 0, 0, 1, 0, X, addr, hit, ea, o, e, have);
      step(0, 0, 0, 0, 0, 1, 1, Y, addr, hit, ea, o, e, have);
      step(0, 0, 0, 0, 0, 1, 2, 1, addr, hit, ea, o, e, have);
      for (int i = 0; i < 90; i++) begin
        vld = (i == 0) || ($urandom_range(0, 4) != 0);
        sof = (i == 0) || (!vld && $urandom_range(0, 3) == 0);
        x = (X + 2048 + $urandom_range(0, 44) - 6) % 2048;
        y = (Y + 2048 + $urandom_range(0, 44) - 6) % 2048;
        we = ($urandom_range(0, 9) == 0);
        a = $urandom_range(0, 3);
        step(vld, sof, x, y, $urandom_range(0, 4095), we, a, $urandom_range(0, 2047),
             addr, hit, ea, o, e, have);
        if (hit) begin
          n_chk++;
          if (addr !== 10'(ea)) begin
            n_fail++; $display("FAIL rand_addr[%0d.%0d]: got %0d, required %0d", f, i, addr, ea);
          end
        end
        if (have) begin
          n_chk++;
          if (o.vld !== e.vld || o.sof !== e.sof || (e.vld && o.rgb !== e.rgb)) begin
            n_fail++;
            $display("FAIL rand_pix[%0d.%0d]: got vld/sof/rgb %b/%b/%h, required %b/%b/%h",
                     f, i, o.vld, o.sof, o.rgb, e.vld, e.sof, e.rgb);
          end
        end
      end
    end
  endtask

  task automatic test_midframe_reset();
    logic [9:0] addr; bit hit, have; int ea; pix_t o, e;
    step(0, 0, 0, 0, 0, 1, 0, 300, addr, hit, ea, o, e, have);
    step(0, 0, 0, 0, 0, 1, 1, 300, addr, hit, ea, o, e, have);
    step(0, 0, 0, 0, 0, 1, 2, 1, addr, hit, ea, o, e, have);
    for (int i = 0; i < 6; i++)
      step(1, i == 0, 300 + i, 300, $urandom_range(1, 4095), 0, 0, 0, addr, hit, ea, o, e, have);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.dst_vld !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_vld: got %b, required 0", bus.dst_vld);
    end
    n_chk++;
    if (bus.dst_rgb !== 12'h000) begin
      n_fail++; $display("FAIL async_reset_rgb: got %h, required 000", bus.dst_rgb);
    end
    do_reset();
    // Position rewritten but EN left at its reset value: no sprite until EN=1 and a new sof.
    step(0, 0, 0, 0, 0, 1, 0, 300, addr, hit, ea, o, e, have);
    step(0, 0, 0, 0, 0, 1, 1, 300, addr, hit, ea, o, e, have);
    for (int i = 0; i < 14; i++) begin
      if (i == 6)
        step(1, 0, 302, 301, $urandom_range(0, 4095), 1, 2, 1, addr, hit, ea, o, e, have);
      else if (i < 12)
        step(1, i == 0 || i == 8, 300 + i, 301, $urandom_range(0, 4095), 0, 0, 0,
             addr, hit, ea, o, e, have);
      else
        step(0, 0, 0, 0, 0, 0, 0, 0, addr, hit, ea, o, e, have);
      if (have) begin
        n_chk++;
        if (o.vld !== e.vld || o.sof !== e.sof || (e.vld && o.rgb !== e.rgb)) begin
          n_fail++;
          $display("FAIL post_reset_pix[%0d]: got vld/sof/rgb %b/%b/%h, required %b/%b/%h",
                   i, o.vld, o.sof, o.rgb, e.vld, e.sof, e.rgb);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_frame_update();
    test_edge();
    test_vld_gaps();
    test_random_frames();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
